rx_word: RTL

Receive-side counterpart of the correlator's hex-word UART transmitter. Deserialises 8N1 UART characters on `RX`, accepts a line of exactly `TOTAL_NIBBLES` ASCII hex digits (MSB nibble first) terminated by carriage return (0x0D), and presents the assembled `RESOLUTION`-bit word with a one-cycle `valid` strobe. Malformed lines are rejected with a one-cycle `err` strobe, and `rx_data` is left unchanged. It sits between the host serial line and the correlator's configuration/command logic.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_byte.sv | 104 ++++++++++
 rtl/rx_word.sv | 94 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII control characters, hex digit decoding and
// the FSM state encodings used by the byte receiver and the line assembler.
package uart_pkg;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    LN_ACCUM,
    LN_DISCARD
  } line_state_t;

  // Returns {is_hex, nibble}; letters of either case map through (c & 7) + 9.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, ({1'b0, c[2:0]} + 4'd9)};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser on RX followed by a
// mid-bit sampling FSM that emits one strobe per good byte or a frame error.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] byte_q,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Synchroniser and edge-history flops reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A start needs a true high-to-low edge, so after a frame error the line
  // has to return high before the next character is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_q    <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= RX_IDLE;
            if (rx_sync) begin
              byte_q   <= shreg;
              byte_stb <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_word.sv
// Hex-word line receiver: collects exactly RESOLUTION/4 ASCII hex digits
// terminated by CR and publishes the word with a valid strobe, or pulses err.
module rx_word
  import uart_pkg::*;
#(
  parameter int RESOLUTION   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX,
  output logic [RESOLUTION-1:0] rx_data,
  output logic                  valid,
  output logic                  err
);

  localparam int TOTAL_NIBBLES = RESOLUTION / 4;
  localparam int CNT_W = $clog2(TOTAL_NIBBLES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_NIBBLES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL_NIBBLES + 1);

  logic [7:0]            byte_q;
  logic                  byte_stb;
  logic                  frame_err;
  logic [4:0]            dec;
  line_state_t           state;
  logic [RESOLUTION-1:0] acc;
  logic [CNT_W-1:0]      cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .byte_q   (byte_q),
    .byte_stb (byte_stb),
    .frame_err(frame_err)
  );

  assign dec = hex_decode(byte_q);

  // The digit count saturates one past full so overlong lines still fail at CR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LN_ACCUM;
      acc     <= '0;
      cnt     <= '0;
      rx_data <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        LN_ACCUM: begin
          if (frame_err) begin
            state <= LN_DISCARD;
          end else if (byte_stb) begin
            if (dec[4]) begin
              acc <= {acc[RESOLUTION-5:0], dec[3:0]};
              if (cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (byte_q == CHR_LF) begin
              state <= LN_ACCUM;
            end else if (byte_q == CHR_CR) begin
              if (cnt == CNT_FULL) begin
                rx_data <= acc;
                valid   <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              acc <= '0;
              cnt <= '0;
            end else begin
              state <= LN_DISCARD;
            end
          end
        end
        LN_DISCARD: begin
          if (byte_stb && byte_q == CHR_CR) begin
            err   <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            state <= LN_ACCUM;
          end
        end
        default: state <= LN_ACCUM;
      endcase
    end
  end

endmodule
